// File: rtl/switch_conditioner_if.sv
// Signal bundle between the raw switch inputs and the conditioned B/C/D outputs.
// The sweep_en member exists only when AUTO_SWEEP_EN is defined.
interface switch_conditioner_if;
    logic [2:0] sw_in;
    logic [2:0] bcd_out;
    logic       changed;
    logic       stable;
`ifdef AUTO_SWEEP_EN
    logic       sweep_en;

    modport master (output sw_in, output sweep_en, input bcd_out, input changed, input stable);
    modport slave  (input sw_in, input sweep_en, output bcd_out, output changed, output stable);
`else
    modport master (output sw_in, input bcd_out, input changed, input stable);
    modport slave  (input sw_in, output bcd_out, output changed, output stable);
`endif
endinterface

// File: rtl/switch_conditioner.sv
// Synchronises and debounces three slide switches into clean {B,C,D} with a change pulse.
// Optional AUTO_SWEEP_EN adds a self-stepping 000..111 test sweep on bcd_out.
module switch_conditioner #(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STEP_CYCLES     = 50000000
) (
    input logic                 clk,
    input logic                 rst_n,
    switch_conditioner_if.slave sc
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 ||
        longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1) ||
        STEP_CYCLES < 1) begin : g_bad_params
        $error("switch_conditioner: illegal DEBOUNCE_CYCLES/STEP_CYCLES for CNT_W");
    end

    logic [2:0]       sync_p0;
    logic [2:0]       sync_p1;
    logic [2:0]       deb_q;
    logic [2:0]       deb_next;
    logic [CNT_W-1:0] cnt_q    [3];
    logic [CNT_W-1:0] cnt_next [3];
    logic             deb_stable;
    logic             changed_q;

    // Stage p0/p1: two-flop synchroniser per switch bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= sc.sw_in;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: a bit only moves after DEBOUNCE_CYCLES unbroken disagreements
    always_comb begin
        deb_next = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_next[i] = '0;
            if (sync_p1[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_next[i] = sync_p1[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_next;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_next[i];
            end
        end
    end

    assign deb_stable = (cnt_q[0] == '0) && (cnt_q[1] == '0) && (cnt_q[2] == '0);

`ifdef AUTO_SWEEP_EN
    localparam int              STEP_W   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_CYCLES - 1);

    logic              sweep_q;
    logic [2:0]        code_q;
    logic [STEP_W-1:0] dwell_q;
    logic [2:0]        bcd_q;

    // Output stage: sweep code overrides the debounced value, which keeps tracking underneath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_q   <= 1'b0;
            code_q    <= '0;
            dwell_q   <= '0;
            bcd_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            sweep_q <= sc.sweep_en;
            if (sc.sweep_en) begin
                if (!sweep_q) begin
                    code_q    <= '0;
                    dwell_q   <= '0;
                    bcd_q     <= '0;
                    changed_q <= (bcd_q != 3'b000);
                end else if (dwell_q == STEP_MAX) begin
                    dwell_q   <= '0;
                    code_q    <= code_q + 3'd1;
                    bcd_q     <= code_q + 3'd1;
                    changed_q <= 1'b1;
                end else begin
                    dwell_q   <= dwell_q + STEP_W'(1);
                    changed_q <= 1'b0;
                end
            end else begin
                code_q    <= '0;
                dwell_q   <= '0;
                bcd_q     <= deb_next;
                changed_q <= (deb_next != bcd_q);
            end
        end
    end

    assign sc.bcd_out = bcd_q;
    assign sc.stable  = sweep_q | deb_stable;
`else
    // Output stage: change pulse registered on the same edge as the debounced update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= (deb_next != deb_q);
        end
    end

    assign sc.bcd_out = deb_q;
    assign sc.stable  = deb_stable;
`endif

    assign sc.changed = changed_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Randomised bench for switch_conditioner with a window-based reference model.
// Sweep scenarios are included when AUTO_SWEEP_EN is defined.
module tb_switch_conditioner;

    localparam int D      = 4;
    localparam int STEP_C = 3;

    logic clk;
    logic rst_n;
    switch_conditioner_if ifc ();

    switch_conditioner #(
        .CNT_W          (4),
        .DEBOUNCE_CYCLES(D),
        .STEP_CYCLES    (STEP_C)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sc   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit done     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a bit flips once the last D synchronised samples all disagree with it
    logic [2:0] samp[$];
    logic [2:0] deb_m;
    logic [2:0] exp_bcd;
    logic       exp_changed;
    logic       exp_stable;
    int         m_edge;
    int         sw_entry;
    bit         sw_prev;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                samp.delete();
                for (int i = 0; i < D + 2; i++) samp.push_front(3'b000);
                deb_m       = 3'b000;
                exp_bcd     = 3'b000;
                exp_changed = 1'b0;
                exp_stable  = 1'b1;
                m_edge      = 0;
                sw_entry    = 0;
                sw_prev     = 0;
            end else begin
                logic [2:0] new_out;
                logic       st;
                bit         all_diff;
                m_edge++;
                samp.push_front(ifc.sw_in);
                void'(samp.pop_back());
                for (int b = 0; b < 3; b++) begin
                    all_diff = 1;
                    for (int j = 0; j < D; j++)
                        if (samp[2 + j][b] == deb_m[b]) all_diff = 0;
                    if (all_diff) deb_m[b] = ~deb_m[b];
                end
                new_out = deb_m;
                st      = (samp[2] == deb_m);
`ifdef AUTO_SWEEP_EN
                if (ifc.sweep_en && !sw_prev) sw_entry = m_edge;
                sw_prev = ifc.sweep_en;
                if (ifc.sweep_en) begin
                    new_out = 3'(((m_edge - sw_entry) / STEP_C) % 8);
                    st      = 1'b1;
                end
`endif
                exp_changed = (new_out != exp_bcd);
                exp_bcd     = new_out;
                exp_stable  = st;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        while (!done) begin
            @(negedge clk);
            if (!done) begin
                if (!rst_n) begin
                    chk("rst_bcd", 32'(ifc.bcd_out), 32'h0);
                    chk("rst_changed", 32'(ifc.changed), 32'h0);
                    chk("rst_stable", 32'(ifc.stable), 32'h1);
                end else begin
                    chk("bcd_out", 32'(ifc.bcd_out), 32'(exp_bcd));
                    chk("changed", 32'(ifc.changed), 32'(exp_changed));
                    chk("stable", 32'(ifc.stable), 32'(exp_stable));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic adv_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic hand(input string name, input logic [2:0] bcd, input logic chg, input logic st);
        @(negedge clk);
        chk({name, "_bcd"}, 32'(ifc.bcd_out), 32'(bcd));
        chk({name, "_changed"}, 32'(ifc.changed), 32'(chg));
        chk({name, "_stable"}, 32'(ifc.stable), 32'(st));
    endtask

    initial begin
        int   last;
        int   r;
        int   e;
        logic [2:0] one;
        one   = 3'b001;
        rst_n = 1'b0;
        ifc.sw_in = 3'b000;
`ifdef AUTO_SWEEP_EN
        ifc.sweep_en = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;

        // Basic latency: change during cycle 10 lands at cycle 16
        adv_to(10); ifc.sw_in = 3'b101;
        adv_to(12); hand("pre_fall", 3'b000, 1'b0, 1'b1);
        adv_to(13); hand("fall13", 3'b000, 1'b0, 1'b0);
        adv_to(15); hand("low15", 3'b000, 1'b0, 1'b0);
        adv_to(16); hand("upd16", 3'b101, 1'b1, 1'b1);
        adv_to(17); hand("post17", 3'b101, 1'b0, 1'b1);

        // Three-cycle pulse on bit 1 is rejected
        adv_to(20); ifc.sw_in = 3'b111;
        adv_to(23); ifc.sw_in = 3'b101;
        adv_to(35); hand("glitch", 3'b101, 1'b0, 1'b1);

        // Bounce on bit 0: update D+2 cycles after the last edge
        ifc.sw_in = 3'b100;
        adv_to(45); hand("bit0_low", 3'b100, 1'b0, 1'b1);
        adv_to(46); ifc.sw_in = 3'b101;
        tick();     ifc.sw_in = 3'b100;
        tick();     ifc.sw_in = 3'b101;
        last = cyc;
        adv_to(last + 5); hand("bounce_wait", 3'b100, 1'b0, 1'b0);
        adv_to(last + 6); hand("bounce_upd", 3'b101, 1'b1, 1'b1);

        // Reset at the second debounce cycle with all switches high
        adv_to(60); ifc.sw_in = 3'b000;
        adv_to(70); ifc.sw_in = 3'b111;
        adv_to(74); rst_n = 1'b0;
        hand("in_reset", 3'b000, 1'b0, 1'b1);
        tick(); tick();
        rst_n = 1'b1;
        last  = cyc;
        adv_to(last + 5); hand("rel_wait", 3'b000, 1'b0, 1'b0);
        adv_to(last + 6); hand("rel_upd", 3'b111, 1'b1, 1'b1);
        adv_to(last + 7); hand("rel_post", 3'b111, 1'b0, 1'b1);

        // Random switch activity with one mid-run reset
        for (int k = 0; k < 600; k++) begin
            if (k == 300) begin
                rst_n = 1'b0;
                tick(); tick();
                rst_n = 1'b1;
            end
            r = int'($urandom_range(0, 9));
            if (r < 2) ifc.sw_in = 3'($urandom_range(0, 7));
            else if (r == 2) ifc.sw_in = ifc.sw_in ^ (one << $urandom_range(0, 2));
            tick();
        end

`ifdef AUTO_SWEEP_EN
        // Sweep through a full wrap, then drop at code 101
        ifc.sw_in = 3'b010;
        adv_to(cyc + 20);
        hand("pre_sweep", 3'b010, 1'b0, 1'b1);
        ifc.sweep_en = 1'b1;
        e = cyc + 1;
        adv_to(e);      hand("sw_enter", 3'b000, 1'b1, 1'b1);
        adv_to(e + 2);  hand("sw_hold0", 3'b000, 1'b0, 1'b1);
        adv_to(e + 3);  hand("sw_step1", 3'b001, 1'b1, 1'b1);
        adv_to(e + 21); hand("sw_step7", 3'b111, 1'b1, 1'b1);
        adv_to(e + 24); hand("sw_wrap", 3'b000, 1'b1, 1'b1);
        adv_to(e + 39); hand("sw_code5", 3'b101, 1'b1, 1'b1);
        adv_to(e + 40); ifc.sweep_en = 1'b0;
        adv_to(e + 41); hand("sw_exit", 3'b010, 1'b1, 1'b1);
        adv_to(e + 42); hand("sw_after", 3'b010, 1'b0, 1'b1);

        // Random sweep toggling on top of switch activity
        for (int k = 0; k < 200; k++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) ifc.sweep_en = ~ifc.sweep_en;
            else if (r < 4) ifc.sw_in = 3'($urandom_range(0, 7));
            tick();
        end
        ifc.sweep_en = 1'b0;
`else
        e = 0;
`endif
        adv_to(cyc + 10);
        @(negedge clk);
        done = 1;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Input conditioning stage for the three-input logic lab designs. It synchronises and debounces three raw slide-switch inputs into clean, glitch-free B, C and D signals for the downstream combinational function block. It also raises a one-cycle pulse whenever the conditioned vector changes.

## Interface
- `CNT_W`, default 16: debounce counter width.
- `DEBOUNCE_CYCLES`, default 50000: consecutive synchronised cycles a new level must persist. Legal range is 2 to 2^CNT_W−1.
- `STEP_CYCLES`, default 50000000: sweep dwell per code. Only used with `AUTO_SWEEP_EN`.
- `clk`, input, 1: single clock; all state on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `sw_in`, input, 3: raw switches, asynchronous to `clk`. Bit 2 = B, bit 1 = C, bit 0 = D.
- `bcd_out`, output, 3: conditioned {B,C,D}, registered. Connects directly to the function block's B, C, D inputs.
- `changed`, output, 1: one-cycle pulse in the cycle `bcd_out` differs from its previous value.
- `stable`, output, 1: high when no bit has a debounce in progress.
- `sweep_en`, input, 1: synchronous. Present only with `AUTO_SWEEP_EN`.

## Operation
- Reset values:
  - `bcd_out` = 3'b000
  - `changed` = 0
  - `stable` = 1
  - synchroniser flops = 0
  - all counters = 0
- Synchroniser: two flops per bit. The synchronised value `s[i]` lags `sw_in[i]` by 2 clocks.
- Per-bit debounce, with independent counter `cnt[i]`:
  - If `s[i] == bcd_out[i]`: `cnt[i]` ← 0.
  - Else, if `cnt[i] == DEBOUNCE_CYCLES−1`: `bcd_out[i]` ← `s[i]` and `cnt[i]` ← 0.
  - Else: `cnt[i]` ← `cnt[i]+1`.
- Glitch handling:
  - A disagreement shorter than `DEBOUNCE_CYCLES` cycles leaves `bcd_out[i]` unchanged.
  - The counter restarts from 0 on every return to agreement. There is no partial credit.
- `changed` is registered alongside `bcd_out`. Several bits updating on the same edge produce one pulse, not several.
- `stable` = 1 when all three `cnt[i]` are 0.
- The counter never wraps. It is bounded by the `DEBOUNCE_CYCLES−1` compare.

## Timing
- Latency from a `sw_in` edge to `bcd_out` update is 2 + `DEBOUNCE_CYCLES` clocks, with `changed` high in that same cycle.
- `stable` falls 3 clocks after a `sw_in` edge: the first cycle `cnt` becomes non-zero. It rises on the edge `bcd_out` updates.
- Bits that switch at different times update in independent cycles, each with its own `changed` pulse.
- Reset asserted mid-debounce: all state returns to reset values immediately, asynchronously. After release, any switch already high is treated as a new change and appears after 2 + `DEBOUNCE_CYCLES` clocks, with a `changed` pulse.
- A switch held high through reset behaves the same way: `bcd_out` starts at 000 and updates after the full latency.

## Configuration
- Macro: `AUTO_SWEEP_EN`.
- Defined:
  - Adds port `sweep_en` and a 3-bit sweep counter plus a dwell counter.
  - While `sweep_en` = 1, `bcd_out` shows the sweep code. The code starts at 000 and advances by 1 every `STEP_CYCLES` clocks, wrapping 111→000.
  - `changed` pulses on every step; `stable` = 1.
  - The debounce path keeps tracking `sw_in` in the background.
  - On the clock `sweep_en` is sampled 1 after being 0, `bcd_out` ← 000, with a `changed` pulse if the previous value differed.
  - On the clock `sweep_en` is sampled 0, `bcd_out` returns to the debounced value, with a `changed` pulse if different. Both sweep counters clear to 0.
- Undefined: no `sweep_en` port and no sweep logic. `bcd_out` is always the debounced value.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `STEP_CYCLES`=3.
- Reset with `sw_in`=000, then `sw_in`→3'b101 at cycle 10 → `bcd_out`=101 at cycle 16, `changed`=1 for exactly cycle 16, `stable` low in cycles 13–15.
- Pulse bit 1 high for 3 cycles only → `bcd_out` stays 000, no `changed`, `stable` returns to 1.
- Bounce: `sw_in[0]` toggles 1,0,1 on consecutive cycles, then holds 1 → `bcd_out[0]`=1 exactly 4 synchronised cycles after the last edge; one `changed` pulse.
- Set `sw_in`=111 and assert `rst_n`=0 for 2 cycles at the second debounce cycle → `bcd_out`=000 during reset; 111 appears 6 cycles after release, with one `changed` pulse.
- `AUTO_SWEEP_EN`, `sweep_en`=1 with switches at 010 → `bcd_out` sequence 000,001,…,111,000, each held 3 cycles, one `changed` per step. Drop `sweep_en` at code 101 → `bcd_out`=010 next clock with a `changed` pulse.
